// File: rtl/rr_arb_pkg.sv
// Shared types, defaults and round-robin pick helper for the rr_mux_arbiter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int RR_DEF_N       = 8;
    localparam int RR_DEF_DATA_W  = 8;
    localparam int RR_DEF_TIMEOUT = 16;

    // Widest request vector the helper accepts; callers zero-extend into it.
    localparam int RR_MAX_N   = 32;
    localparam int RR_IDX_W   = $clog2(RR_MAX_N);

    // Circular first-set search over req[0..n-1], starting just after 'last'.
    // Returns the winning index, or -1 when no bit is set.
    function automatic int rr_pick(input logic [RR_MAX_N-1:0] req,
                                   input int                  last,
                                   input int                  n);
        int pick;
        int idx;
        pick = -1;
        for (int k = 1; k <= RR_MAX_N; k++) begin
            idx = (last + k) % n;
            if ((k <= n) && (pick < 0) && req[idx[RR_IDX_W-1:0]]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin priority picker: first set request after ptr_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found_o=0 and idx_o=0 when no request is set.
// Ports: req_i (N requests), ptr_i (last winner), idx_o (winner), found_o (any request).
module rr_pick_n
    import rr_arb_pkg::*;
#(
    parameter  int N     = RR_DEF_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    logic [RR_MAX_N-1:0] req_ext;
    int                  pick;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req_i;
        pick           = rr_pick(req_ext, int'(ptr_i), N);
        found_o        = (pick >= 0);
        idx_o          = found_o ? pick[SEL_W-1:0] : '0;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter driving a shared N:1 valid/ready mux; grant held until a last beat.
// Latency: 1 cycle from valid seen in IDLE to first possible transfer; 1 beat/cycle within a packet.
// Backpressure: out_ready is routed to the granted requester only; others see in_ready=0 and wait.
// Ports: clk, rst_n (async active-low); in_valid/in_data/in_last/in_ready per requester;
//        out_valid/out_data/out_last/out_ready downstream; sel (registered grant index), busy.
// Option: define RR_ARB_TIMEOUT_EN to add the TIMEOUT parameter, an idle-beat release counter
//         and the timeout_o pulse output.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N       = RR_DEF_N,
    parameter  int DATA_W  = RR_DEF_DATA_W,
`ifdef RR_ARB_TIMEOUT_EN
    parameter  int TIMEOUT = RR_DEF_TIMEOUT,
`endif
    localparam int SEL_W   = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_valid,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [N-1:0]        in_last,
    output logic [N-1:0]        in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic [SEL_W-1:0]    sel,
    output logic                busy
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic                timeout_o
`endif
);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic             busy_q, busy_d;

    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             xfer;

    // Unpacked view of the packed data bus so the mux index is exactly SEL_W bits.
    logic [DATA_W-1:0] data_arr [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    rr_pick_n #(
        .N (N)
    ) u_pick (
        .req_i   (in_valid),
        .ptr_i   (last_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        busy_d    = busy_q;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        xfer      = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    sel_d   = win_idx;
                    last_d  = win_idx;
                    busy_d  = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                out_valid       = in_valid[sel_q];
                out_data        = data_arr[sel_q];
                out_last        = in_last[sel_q];
                in_ready[sel_q] = out_ready;
                xfer            = in_valid[sel_q] && out_ready;
                if (xfer && in_last[sel_q]) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
`ifdef RR_ARB_TIMEOUT_EN
                if (xfer) begin
                    to_cnt_d = '0;
                end else if (!in_valid[sel_q]) begin
                    // Release on the TIMEOUT-th consecutive idle grant cycle.
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        to_cnt_d  = '0;
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            // Pointer starts at N-1 so the first search begins at requester 0.
            last_q  <= SEL_W'(N - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`endif

    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared N:1 mux datapath; each requester is a valid/ready stream with a last flag.
- Grants one requester at a time, drives the mux select, and holds the grant until that requester's packet completes (beat with last).
- Sits in front of a single downstream consumer that several producers share.

Parameters:
- N, 8, number of requesters; must be a power of 2 and at least 2.
- DATA_W, 8, width of each requester's data in bits.
- SEL_W, $clog2(N), width of the select; derived, not overridden.
- TIMEOUT, 16, idle-beat limit before forced release; used only when RR_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N  per-requester valid.
- in_data  in  N*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  N  per-requester end-of-packet flag.
- in_ready  out  N  per-requester ready; one-hot or zero.
- out_valid  out  1  muxed valid.
- out_data  out  DATA_W  muxed data.
- out_last  out  1  muxed last.
- out_ready  in  1  downstream ready.
- sel  out  SEL_W  current grant index, registered.
- busy  out  1  high while a grant is held.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, sel=0, busy=0.
  - Pointer last_grant=N-1, so the first search starts at requester 0.
  - All outputs go to 0: in_ready=0, out_valid=0, out_data=0, out_last=0.
- States: IDLE and GRANT.
- IDLE:
  - If |in_valid, the winner is the first set bit searching circularly from (last_grant+1) mod N.
  - On the clock edge: sel<=winner, last_grant<=winner, busy<=1, state<=GRANT.
  - Grant latency is 1 cycle from valid seen to first possible transfer.
  - If no valid, remain in IDLE.
  - In IDLE, out_valid=0 and in_ready=0.
- GRANT (combinational outputs):
  - out_valid=in_valid[sel], out_data=in_data[sel], out_last=in_last[sel].
  - in_ready[sel]=out_ready; all other in_ready bits are 0.
- Transfer condition: out_valid && out_ready.
- A transfer with out_last=1 ends the packet: state<=IDLE, busy<=0. sel holds its value.
- Back-to-back packets: at least one IDLE cycle always separates packets. Peak throughput is one beat per cycle within a packet.
- Granted requester drops valid mid-packet: the grant is held and out_valid=0. No other requester is served (without RR_ARB_TIMEOUT_EN).
- Non-granted requesters may assert valid at any time. They see in_ready=0 and wait.
- Fairness: a requester that just finished has the lowest priority at the next arbitration. The pointer wraps from N-1 to 0.
- Single-beat packet (last on the first beat): GRANT lasts exactly 1 cycle if out_ready=1.
- Reset asserted mid-packet: everything returns to reset values immediately. The partial packet is abandoned, with no recovery.
- in_data/in_last of non-granted requesters are don't-care.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) increments each GRANT cycle in which in_valid[sel]=0.
  - The counter clears on any transfer and on entry to GRANT.
  - When it reaches TIMEOUT, the block forces state<=IDLE and busy<=0, and pulses output timeout_o (1 cycle, registered).
  - timeout_o exists only when the macro is defined and resets to 0.
- Undefined: no counter and no timeout_o port; a grant is held indefinitely as described above.

Decomposition:
- Shared package rr_arb_pkg:
  - State enum: IDLE=1'b0, GRANT=1'b1.
  - Default parameter constants.
  - A function rr_pick(req, last) that returns the circular first-set index.
- One natural sub-module: rr_pick_n, a combinational round-robin priority picker (N-bit request, SEL_W-bit pointer → SEL_W-bit index plus found flag). It is reusable by other arbiters.
- The data mux is inline and is the existing mux datapath role.

Test Plan:
- Reset, then in_valid=8'b0000_0001 with a 3-beat packet (data 0xA1,0xA2,0xA3; last on the 3rd), out_ready=1:
  - sel=0 and busy=1 one cycle after valid.
  - 3 transfers on consecutive cycles, with out_last on 0xA3.
  - busy=0 on the next cycle.
- All 8 requesters valid with 1-beat packets (data = index), out_ready=1 → grant order 0,1,2,…,7,0. Each transfer is separated by one IDLE cycle.
- Requester 5 mid-packet and requester 2 valid; out_ready toggles 1,0,1 → requester 5 completes its packet. out_data is stable while out_ready=0. Requester 2 is granted next, and in_ready[2]=0 throughout requester 5's packet.
- After requester 7 is served, requesters 0 and 6 are both valid → requester 0 wins (wrap-around). Then requester 6 is served.
- rst_n pulled low on the 2nd beat of a 4-beat packet → busy, in_ready and out_valid drop asynchronously. After release, arbitration restarts from requester 0.
- RR_ARB_TIMEOUT_EN with TIMEOUT=4: requester 3 is granted, then drops valid for 4 cycles → timeout_o pulses once, busy=0, and a pending requester 4 is granted next.
